uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive end of the serial link driven by the team's transmit shift register. It synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each bit at mid-bit. It deserialises 8 data bits LSB-first, optionally checks even parity, and checks the stop bit. Each received byte is presented with a one-cycle valid pulse and error flags to the host-side logic.

## Interface
- `CLKS_PER_BIT`, default 868 — clock cycles per bit period (100 MHz / 115200); must be ≥ 4.
- `PARITY_EN`, default 0 — 1: one even-parity bit follows the data bits.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `rx_data`  out  8  last received byte; holds until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` and the error flags are valid.
- `frame_err`  out  1  stop bit sampled 0; qualified by `rx_valid`, held with `rx_data`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`, held; always 0 when `PARITY_EN`=0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised `rxs`.
- State machine:
  - IDLE: a 1→0 transition of `rxs` → START, bit counter cleared.
  - START: at count `CLKS_PER_BIT/2 - 1` (integer division), sample `rxs`.
    - 0 → DATA, counter restarts.
    - 1 → IDLE (glitch rejected, no output activity).
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxs` into the SIPO (shift right, new bit at MSB). After the 8th sample → PARITY if `PARITY_EN`, else STOP.
  - PARITY: one bit period later, sample `rxs`. Error if XOR(data bits, parity bit) ≠ 0 → STOP.
  - STOP: one bit period later, sample `rxs`.
    - Cycle after the sample: update `rx_data`, `frame_err` = ~sample, and `parity_err`; pulse `rx_valid`.
    - Sample 1 → IDLE. Sample 0 → WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then → IDLE. A break condition yields exactly one frame with `frame_err`=1.
- The receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is received. Back-to-back frames with no idle time are supported.
- Bit counter width is `$clog2(CLKS_PER_BIT)`; it wraps to 0 on each sample.
- There is no overrun flag. A new frame overwrites `rx_data` regardless of whether the host consumed the previous one.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0; state IDLE; synchroniser flops 1.
- Edge-detect latency: `rx` fall → START entry is 3 cycles (2 synchroniser cycles + 1 edge-detect cycle).
- Sample points: start bit at `CLKS_PER_BIT/2` cycles after START entry; bit k (k=0..7) at `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT` after START entry.
- `rx_valid` latency from START entry: `CLKS_PER_BIT/2 + (9+PARITY_EN)*CLKS_PER_BIT + 1` cycles.
- `rx_valid` is never high for two consecutive cycles.
- Reset mid-frame aborts immediately: outputs take reset values, no `rx_valid`. If `rx` is low when reset releases, no start is detected until a fresh 1→0 transition.

## Structure
- Package `uart_pkg`:
  - `DATA_BITS` = 8.
  - State enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}.
  - Shared with the transmit side for frame-format constants.
- Sub-module `rx_sipo`: 8-bit serial-in parallel-out register with `shift` and `clr` inputs, input bit entering at MSB, parallel output.
- FSM, bit counter, synchroniser and parity accumulator live in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Frame 0xA5, `PARITY_EN`=0, stop=1 → `rx_data`=0xA5, one-cycle `rx_valid`, `frame_err`=0, `parity_err`=0; `busy` low after mid-stop.
- `rx` low pulse of 5 cycles from idle → START entered, returns to IDLE at mid-bit; no `rx_valid`; `rx_data` unchanged.
- Frame 0x3C with stop bit 0, line held low 40 more cycles → `rx_valid` with `rx_data`=0x3C, `frame_err`=1. No further `rx_valid` until the line returns high and a new start arrives.
- `PARITY_EN`=1:
  - 0x07 with parity bit 1 → `parity_err`=0.
  - 0x07 with parity bit 0 → `parity_err`=1.
- Back-to-back frames 0x00 then 0xFF, no idle between the stop bit and the next start → two `rx_valid` pulses exactly `10*CLKS_PER_BIT` cycles apart, with correct data.
- `rst_n` asserted at data bit 4 of 0x55 → all outputs 0 immediately, no `rx_valid`. A subsequent 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame-format constants and receiver state
// encoding shared by the UART transmit and receive sides.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/rx_sipo.sv
// rx_sipo: serial-in parallel-out register for the receiver.
// Bits enter at the MSB so an LSB-first frame lands in order.
module rx_sipo
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_i,
  input  logic                 clr_i,
  input  logic                 bit_i,
  output logic [DATA_BITS-1:0] data_o
);

  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {bit_i, data_q[DATA_BITS-1:1]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 8 data bits,
// optional even parity, one stop bit, one-cycle valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int NBW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);

  logic s1_q, rxs_q, prev_q;
  logic [1:0] arm_q;
  logic fall;

  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NBW-1:0] nbit_q;
  logic par_q, perr_q, done_q, stop_q;
  logic shift, clr;
  logic tick_half, tick_full, last_bit;
  logic [DATA_BITS-1:0] sipo_data;

  logic [DATA_BITS-1:0] data_q;
  logic valid_q, ferr_q, perr_o_q;

  // arm_q keeps the reset value of the synchroniser from
  // looking like a real 1->0 edge when rx is low at release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b0;
      arm_q  <= 2'b00;
    end else begin
      s1_q   <= rx;
      rxs_q  <= s1_q;
      arm_q  <= {arm_q[0], 1'b1};
      prev_q <= rxs_q & arm_q[1];
    end
  end

  assign fall      = prev_q & ~rxs_q;
  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);
  assign last_bit  = (nbit_q == NBW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (fall) state_d = START;
      START:
        if (tick_half)
          state_d = (rxs_q == START_BIT) ? DATA : IDLE;
      DATA:
        if (tick_full && last_bit)
          state_d = PARITY_EN ? PARITY : STOP;
      PARITY:
        if (tick_full) state_d = STOP;
      STOP:
        if (tick_full)
          state_d = (rxs_q == STOP_BIT) ? IDLE : WAIT_HIGH;
      WAIT_HIGH:
        if (rxs_q) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    shift = 1'b0;
    clr   = 1'b0;
    cnt_d = cnt_q + 1'b1;
    busy  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clr   = fall;
      end
      START:
        if (tick_half) cnt_d = '0;
      DATA: begin
        shift = tick_full;
        if (tick_full) cnt_d = '0;
      end
      PARITY, STOP:
        if (tick_full) cnt_d = '0;
      default:
        cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      nbit_q   <= '0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_o_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      done_q  <= (state_q == STOP) && tick_full;
      valid_q <= done_q;
      if (clr) begin
        nbit_q <= '0;
        par_q  <= 1'b0;
        perr_q <= 1'b0;
      end else if (shift) begin
        nbit_q <= nbit_q + 1'b1;
        par_q  <= par_q ^ rxs_q;
      end else if (state_q == PARITY && tick_full) begin
        perr_q <= par_q ^ rxs_q;
      end
      if (state_q == STOP && tick_full)
        stop_q <= rxs_q;
      if (done_q) begin
        data_q   <= sipo_data;
        ferr_q   <= (stop_q != STOP_BIT);
        perr_o_q <= PARITY_EN & perr_q;
      end
    end
  end

  rx_sipo u_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (shift),
    .clr_i   (clr),
    .bit_i   (rxs_q),
    .data_o  (sipo_data)
  );

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_o_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: two receivers (no parity / even parity) driven
// by a frame generator and checked against a timing model.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    int         ch;
    int         cyc;
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       bz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxl [2];
  logic [7:0] dat [2];
  logic       vld [2];
  logic       fe  [2];
  logic       pe  [2];
  logic       bz  [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [7:0] last_d [2];
  logic last_fe [2];
  logic last_pe [2];
  logic pv [2];
  int   vt [2];
  int   pvt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rxl[0]),
    .rx_data(dat[0]), .rx_valid(vld[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .busy(bz[0])
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rxl[1]),
    .rx_data(dat[1]), .rx_valid(vld[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .busy(bz[1])
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int ch, input logic v,
                       input int n);
    rxl[ch] = v;
    repeat (n) @(negedge clk);
  endtask

  // model: valid arrives a fixed number of cycles after the
  // start edge is driven; contents follow the frame fields
  task automatic send_frame(input int ch, input logic [7:0] b,
                            input logic pbit, input logic stop,
                            input int extra_low);
    exp_t e;
    int   p;
    p     = (ch == 1) ? 1 : 0;
    e.ch  = ch;
    e.cyc = cyc + 4 + HALF + (9 + p) * CPB;
    e.d   = b;
    e.fe  = ~stop;
    e.pe  = (p == 1) ? ((^b) ^ pbit) : 1'b0;
    e.bz  = ~stop;
    q.push_back(e);
    drive(ch, 1'b0, CPB);
    for (int k = 0; k < 8; k++) drive(ch, b[k], CPB);
    if (p == 1) drive(ch, pbit, CPB);
    drive(ch, stop, CPB);
    if (!stop) drive(ch, 1'b0, extra_low);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_valid", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      for (int c = 0; c < 2; c++) begin
        chk("valid_twice", int'(vld[c] && pv[c]), 0);
        if (vld[c]) begin
          if (q.size() > 0 && q[0].ch == c &&
              q[0].cyc == cyc) begin
            chk("data", dat[c], q[0].d);
            chk("frame_err", fe[c], q[0].fe);
            chk("parity_err", pe[c], q[0].pe);
            chk("busy_at_valid", bz[c], q[0].bz);
            last_d[c]  = q[0].d;
            last_fe[c] = q[0].fe;
            last_pe[c] = q[0].pe;
            pvt[c] = vt[c];
            vt[c]  = cyc;
            void'(q.pop_front());
          end else begin
            chk("unexpected_valid", cyc,
                q.size() > 0 ? q[0].cyc : -1);
          end
        end else begin
          chk("hold_data", dat[c], last_d[c]);
          chk("hold_fe", fe[c], last_fe[c]);
          chk("hold_pe", pe[c], last_pe[c]);
        end
        pv[c] = vld[c];
      end
    end
  end

  initial begin
    int t0;
    logic [7:0] b55;
    for (int c = 0; c < 2; c++) begin
      rxl[c] = 1'b1; last_d[c] = '0; last_fe[c] = 1'b0;
      last_pe[c] = 1'b0; pv[c] = 1'b0; vt[c] = 0; pvt[c] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_valid", vld[c], 0);
      chk("rst_data", dat[c], 0);
      chk("rst_fe", fe[c], 0);
      chk("rst_pe", pe[c], 0);
      chk("rst_busy", bz[c], 0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    t0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    drive(0, 1'b1, 20);
    chk("a5_data", dat[0], 8'hA5);
    chk("a5_fe", fe[0], 0);
    chk("a5_pe", pe[0], 0);
    chk("a5_busy", bz[0], 0);
    chk("a5_latency", vt[0] - t0, 156);

    drive(0, 1'b0, 4);
    chk("glitch_busy", bz[0], 1);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 20);
    chk("glitch_idle", bz[0], 0);
    chk("glitch_data", dat[0], 8'hA5);
    chk("glitch_novalid", vt[0] - t0, 156);

    send_frame(0, 8'h3C, 1'b0, 1'b0, 40);
    drive(0, 1'b1, 20);
    chk("brk_data", dat[0], 8'h3C);
    chk("brk_fe", fe[0], 1);
    chk("brk_idle", bz[0], 0);

    send_frame(1, 8'h07, 1'b1, 1'b1, 0);
    drive(1, 1'b1, 20);
    chk("par_ok_data", dat[1], 8'h07);
    chk("par_ok_pe", pe[1], 0);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0);
    drive(1, 1'b1, 20);
    chk("par_bad_pe", pe[1], 1);
    chk("par_bad_fe", fe[1], 0);

    send_frame(0, 8'h00, 1'b0, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
    drive(0, 1'b1, 20);
    chk("b2b_gap", vt[0] - pvt[0], 160);
    chk("b2b_data", dat[0], 8'hFF);

    b55 = 8'h55;
    drive(0, 1'b0, CPB);
    for (int k = 0; k < 4; k++) drive(0, b55[k], CPB);
    drive(0, b55[4], HALF);
    rst_n = 1'b0;
    rxl[0] = 1'b0;
    q.delete();
    for (int c = 0; c < 2; c++) begin
      last_d[c] = '0; last_fe[c] = 1'b0; last_pe[c] = 1'b0;
    end
    #1;
    chk("arst_data0", dat[0], 0);
    chk("arst_busy0", bz[0], 0);
    chk("arst_valid0", vld[0], 0);
    chk("arst_data1", dat[1], 0);
    chk("arst_pe1", pe[1], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 20);
    chk("low_release_busy", bz[0], 0);
    drive(0, 1'b1, 10);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    drive(0, 1'b1, 20);
    chk("post_rst_data", dat[0], 8'h81);

    for (int i = 0; i < 60; i++) begin
      int   ch;
      int   gap;
      logic stop;
      logic [7:0] b;
      logic pbit;
      ch   = $urandom_range(0, 1);
      b    = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ^b : ~(^b);
      stop = ($urandom_range(0, 6) != 0);
      send_frame(ch, b, pbit, stop, $urandom_range(0, 40));
      if (stop)
        gap = ($urandom_range(0, 2) == 0) ? 0 :
              $urandom_range(1, 20);
      else
        gap = $urandom_range(2, 20);
      drive(ch, 1'b1, gap);
      if ($urandom_range(0, 6) == 0) begin
        drive(ch, 1'b0, $urandom_range(1, HALF));
        drive(ch, 1'b1, $urandom_range(4, 10));
      end
    end

    drive(0, 1'b1, 300);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
